meter_peak_hold: RTL

METER_PEAK_HOLD -- requirements
Module: meter_peak_hold

---
 rtl/meter_pkg.sv | 37 +++
 rtl/meter_peak_ram.sv | 42 ++++
 rtl/meter_peak_hold.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : meter_pkg
// Purpose  : Shared types and helpers for the peak-hold meter store.
// Revision : 1.0
// ============================================================================
package meter_pkg;

  localparam int DEF_DATA_WIDTH = 36;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int MAG_WIDTH      = DEF_DATA_WIDTH - 1;

  // The sign bit of a magnitude is always zero, so only MAG_WIDTH bits are stored.
  typedef struct packed {
    logic                 tag;
    logic [MAG_WIDTH-1:0] peak;
  } meter_entry_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } meter_state_e;

  function automatic logic [MAG_WIDTH-1:0] sat_abs(input logic [DEF_DATA_WIDTH-1:0] x);
    logic [DEF_DATA_WIDTH-1:0] neg;
    neg = ~x + DEF_DATA_WIDTH'(1);
    if (!x[DEF_DATA_WIDTH-1]) begin
      sat_abs = x[MAG_WIDTH-1:0];
    end else if (neg[DEF_DATA_WIDTH-1]) begin
      sat_abs = '1;
    end else begin
      sat_abs = neg[MAG_WIDTH-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/meter_peak_ram.sv
`default_nettype none
// ============================================================================
// Module   : meter_peak_ram
// Purpose  : Simple dual-port peak/tag store with registered update read port
//            and an independent registered readback port.
// Revision : 1.0
// ============================================================================
module meter_peak_ram
  import meter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  meter_entry_t          wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output meter_entry_t          rdata_o,
  input  logic [ADDR_WIDTH-1:0] rb_addr_i,
  output logic [MAG_WIDTH-1:0]  rb_peak_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  meter_entry_t         mem_q [DEPTH];
  meter_entry_t         rdata_q;
  logic [MAG_WIDTH-1:0] rb_peak_q;

  // Both read ports return the pre-write contents on an address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q   <= mem_q[raddr_i];
    rb_peak_q <= mem_q[rb_addr_i].peak;
  end

  assign rdata_o   = rdata_q;
  assign rb_peak_o = rb_peak_q;

endmodule
`default_nettype wire

// File: rtl/meter_peak_hold.sv
`default_nettype none
// ============================================================================
// Module   : meter_peak_hold
// Purpose  : Per-meter peak-hold store with epoch-tagged decay and readback.
// Revision : 1.0
// ============================================================================
module meter_peak_hold
  import meter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DECAY_SHIFT  = 4,
  parameter int DECAY_FRAMES = 64
) (
  input  logic                  dsp_clk,
  input  logic                  reset_n,
  input  logic                  aux_in_en,
  input  logic [ADDR_WIDTH-1:0] aux_in_addr,
  input  logic [DATA_WIDTH-1:0] aux_in_data,
  input  logic                  frame_tick,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done
);

  localparam int              FC_W    = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(DECAY_FRAMES - 1);

  meter_state_e          state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_done_q;

  logic [FC_W-1:0]       fc_q;
  logic                  epoch_q;

  logic                  s0_valid_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q;
  logic [MAG_WIDTH-1:0]  s0_mag_q;

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [MAG_WIDTH-1:0]  s1_mag_q;

  logic                  fwd_valid_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  meter_entry_t          fwd_entry_q;

  logic                  rb_valid_q;

  meter_entry_t          w_ram_rdata;
  logic [MAG_WIDTH-1:0]  w_rb_peak;
  logic                  w_fwd_hit;
  meter_entry_t          w_old;
  logic [MAG_WIDTH-1:0]  w_old_peak;
  meter_entry_t          w_new;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  meter_entry_t          w_ram_wdata;

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      fc_q    <= '0;
      epoch_q <= 1'b0;
    end else if (frame_tick) begin
      if (fc_q == FC_LAST) begin
        fc_q    <= '0;
        epoch_q <= ~epoch_q;
      end else begin
        fc_q <= fc_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q  <= 1'b0;
      s0_addr_q   <= '0;
      s0_mag_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_mag_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_entry_q <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      s0_valid_q  <= aux_in_en && (state_q == ST_RUN);
      s0_addr_q   <= aux_in_addr;
      s0_mag_q    <= sat_abs(DEF_DATA_WIDTH'(aux_in_data));
      s1_valid_q  <= s0_valid_q;
      s1_addr_q   <= s0_addr_q;
      s1_mag_q    <= s0_mag_q;
      fwd_valid_q <= s1_valid_q;
      fwd_addr_q  <= s1_addr_q;
      fwd_entry_q <= w_new;
      rb_valid_q  <= (state_q == ST_RUN);
    end
  end

  // The RAM read for an update one cycle behind a same-address write sees the
  // pre-write contents, so the last written entry is substituted instead.
  assign w_fwd_hit = fwd_valid_q && (fwd_addr_q == s1_addr_q);

  always_comb begin
    w_old      = w_fwd_hit ? fwd_entry_q : w_ram_rdata;
    w_old_peak = w_old.peak;
    if (w_old.tag != epoch_q) begin
      w_old_peak = w_old.peak - (w_old.peak >> DECAY_SHIFT);
    end
    w_new.tag  = epoch_q;
    w_new.peak = (s1_mag_q > w_old_peak) ? s1_mag_q : w_old_peak;
  end

  always_comb begin
    w_ram_we    = s1_valid_q;
    w_ram_waddr = s1_addr_q;
    w_ram_wdata = w_new;
    if (state_q == ST_INIT) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = init_addr_q;
      w_ram_wdata = '0;
    end
  end

  meter_peak_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i     (dsp_clk),
    .we_i      (w_ram_we),
    .waddr_i   (w_ram_waddr),
    .wdata_i   (w_ram_wdata),
    .raddr_i   (s0_addr_q),
    .rdata_o   (w_ram_rdata),
    .rb_addr_i (rd_addr),
    .rb_peak_o (w_rb_peak)
  );

  assign rd_data   = rb_valid_q ? DATA_WIDTH'({1'b0, w_rb_peak}) : '0;
  assign init_done = init_done_q;

endmodule
`default_nettype wire
